// File: rtl/accum_pkg.sv
// accum_pkg: shared state encoding and default sizing for the bin accumulator.
`default_nettype none

package accum_pkg;

  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 128;
  localparam int DEF_IN_WIDTH   = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_ADD   = 3'd2,
    ST_WRITE = 3'd3,
    ST_CLEAR = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sat_adder.sv
// sat_adder: unsigned add of a stored sum and an increment, clamped to all-ones on overflow.
`default_nettype none

module sat_adder #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_WIDTH   = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [IN_WIDTH-1:0]   b,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  overflow
);

  // One guard bit above the wider operand so no carry is ever lost.
  localparam int SUM_W = ((DATA_WIDTH > IN_WIDTH) ? DATA_WIDTH : IN_WIDTH) + 1;

  logic [SUM_W-1:0] full_sum;

  assign full_sum = SUM_W'(a) + SUM_W'(b);
  assign overflow = |full_sum[SUM_W-1:DATA_WIDTH];
  assign sum      = overflow ? {DATA_WIDTH{1'b1}} : full_sum[DATA_WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/bin_accumulator.sv
// bin_accumulator: read-modify-write histogram bin incrementer with saturation
// and a full-memory clear sweep, driving an external registered-read sum memory.
`default_nettype none

module bin_accumulator
  import accum_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int IN_WIDTH   = DEF_IN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_bin,
  input  logic [IN_WIDTH-1:0]   i_value,
  input  logic                  i_clear,
  output logic                  o_busy,
  output logic                  o_clear_done,
  output logic                  o_sat,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_write,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state;
  state_t                  state_nxt;

  logic [ADDR_WIDTH-1:0]   bin_q;
  logic [IN_WIDTH-1:0]     value_q;
  logic [DATA_WIDTH-1:0]   sum_q;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic                    sat_q;
  logic                    done_q;

  logic                    accept;
  logic                    start_clear;
  logic                    do_add;
  logic                    clr_step;
  logic                    clr_last;

  logic [DATA_WIDTH-1:0]   add_sum;
  logic                    add_ovf;

  sat_adder #(
    .DATA_WIDTH (DATA_WIDTH),
    .IN_WIDTH   (IN_WIDTH)
  ) u_sat_adder (
    .a        (i_mem_rdata),
    .b        (value_q),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  assign clr_last = (clr_addr == LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    o_ready     = 1'b0;
    o_busy      = 1'b1;
    o_mem_write = 1'b0;
    o_mem_addr  = bin_q;
    o_mem_wdata = '0;
    accept      = 1'b0;
    start_clear = 1'b0;
    do_add      = 1'b0;
    clr_step    = 1'b0;

    case (state)
      ST_IDLE: begin
        o_ready = 1'b1;
        o_busy  = 1'b0;
        // A clear request wins over a simultaneous increment request.
        if (i_clear) begin
          start_clear = 1'b1;
          state_nxt   = ST_CLEAR;
        end else if (i_valid) begin
          accept    = 1'b1;
          state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        state_nxt = ST_ADD;
      end
      ST_ADD: begin
        do_add    = 1'b1;
        state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        o_mem_write = 1'b1;
        o_mem_wdata = sum_q;
        state_nxt   = ST_IDLE;
      end
      ST_CLEAR: begin
        o_mem_write = 1'b1;
        o_mem_addr  = clr_addr;
        clr_step    = 1'b1;
        if (clr_last) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q    <= '0;
      value_q  <= '0;
      sum_q    <= '0;
      clr_addr <= '0;
      sat_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (accept) begin
        bin_q   <= i_bin;
        value_q <= i_value;
      end

      if (do_add) begin
        sum_q <= add_sum;
        if (add_ovf) begin
          sat_q <= 1'b1;
        end
      end

      if (start_clear) begin
        clr_addr <= '0;
      end else if (clr_step) begin
        clr_addr <= clr_addr + 1'b1;
        if (clr_last) begin
          sat_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign o_sat        = sat_q;
  assign o_clear_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_bin_accumulator.sv
// tb_bin_accumulator: table-driven and scoreboard checks of bin_accumulator
// against a behavioural registered-read sum memory.
`default_nettype none

module tb_bin_accumulator;

  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int DEPTH = 128;
  localparam int IW    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [AW-1:0] i_bin;
  logic [IW-1:0] i_value;
  logic          i_clear;
  logic          o_busy;
  logic          o_clear_done;
  logic          o_sat;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_write;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;

  bin_accumulator #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .IN_WIDTH   (IW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_bin        (i_bin),
    .i_value      (i_value),
    .i_clear      (i_clear),
    .o_busy       (o_busy),
    .o_clear_done (o_clear_done),
    .o_sat        (o_sat),
    .o_mem_addr   (o_mem_addr),
    .o_mem_write  (o_mem_write),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rdata  (i_mem_rdata)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem   [DEPTH];
  logic [DW-1:0] model [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'hA5;
  end

  always @(posedge clk) begin
    if (o_mem_write) mem[o_mem_addr] <= o_mem_wdata;
    i_mem_rdata <= mem[o_mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            at_cyc;
  } exp_t;

  exp_t exp_q[$];
  bit   clearing = 1'b0;
  int   clr_idx  = 0;

  always @(negedge clk) begin
    if (rst_n && o_mem_write) begin
      if (clearing) begin
        chk("clear_addr", 32'(o_mem_addr), 32'(clr_idx));
        chk("clear_data", 32'(o_mem_wdata), 32'd0);
        clr_idx++;
      end else if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0d data %0d, expected no write", o_mem_addr, o_mem_wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(o_mem_addr), 32'(e.addr));
        chk("write_data", 32'(o_mem_wdata), 32'(e.data));
        chk("write_cycle", 32'(cyc), 32'(e.at_cyc));
      end
    end
  end

  function automatic logic [DW-1:0] sadd(input logic [DW-1:0] a, input logic [IW-1:0] b);
    int s;
    s = int'(a) + int'(b);
    return (s > 255) ? 8'hFF : DW'(s);
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [AW-1:0] b, input logic [IW-1:0] v,
                      input logic [DW-1:0] exp, input bit hold, output int acc);
    int n = 0;
    exp_t e;
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(o_ready), 32'd1);
    i_valid = 1'b1;
    i_bin   = b;
    i_value = v;
    e.addr   = b;
    e.data   = exp;
    e.at_cyc = cyc + 3;
    exp_q.push_back(e);
    model[b] = exp;
    acc = cyc + 1;
    @(negedge clk);
    if (!hold) i_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", 32'(o_busy), 32'd0);
  endtask

  task automatic do_clear(input bit with_valid);
    int start;
    int n  = 0;
    int nz = 0;
    i_clear = 1'b1;
    if (with_valid) begin
      i_valid = 1'b1;
      i_bin   = 7'd3;
      i_value = 8'd1;
    end
    clearing = 1'b1;
    clr_idx  = 0;
    start    = cyc;
    @(negedge clk);
    i_clear = 1'b0;
    i_valid = 1'b0;
    chk("clear_busy", 32'(o_busy), 32'd1);
    chk("clear_not_ready", 32'(o_ready), 32'd0);
    while (!o_clear_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("clear_done_seen", 32'(o_clear_done), 32'd1);
    chk("clear_latency", 32'(cyc - start), 32'd129);
    clearing = 1'b0;
    chk("clear_write_count", 32'(clr_idx), 32'(DEPTH));
    chk("clear_sat", 32'(o_sat), 32'd0);
    for (int i = 0; i < DEPTH; i++) if (mem[i] != '0) nz++;
    chk("clear_all_zero", 32'(nz), 32'd0);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    @(negedge clk);
    chk("clear_done_pulse", 32'(o_clear_done), 32'd0);
  endtask

  typedef struct {
    logic [AW-1:0] bin;
    logic [IW-1:0] value;
    logic [DW-1:0] exp_data;
    logic          exp_sat;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    int a0, a1, a2;

    vecs[0] = '{7'd5,   8'd3,   8'd3,   1'b0};
    vecs[1] = '{7'd5,   8'd3,   8'd6,   1'b0};
    vecs[2] = '{7'd127, 8'd200, 8'd200, 1'b0};
    vecs[3] = '{7'd127, 8'd55,  8'd255, 1'b0};
    vecs[4] = '{7'd9,   8'd250, 8'd250, 1'b0};
    vecs[5] = '{7'd9,   8'd10,  8'd255, 1'b1};
    vecs[6] = '{7'd9,   8'd0,   8'd255, 1'b1};
    vecs[7] = '{7'd5,   8'd255, 8'd255, 1'b1};

    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_bin   = '0;
    i_value = '0;
    i_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_mem_write", 32'(o_mem_write), 32'd0);
    chk("rst_sat", 32'(o_sat), 32'd0);
    chk("rst_clear_done", 32'(o_clear_done), 32'd0);
    chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(o_mem_wdata), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(o_ready), 32'd1);

    do_clear(1'b0);

    foreach (vecs[i]) begin
      send(vecs[i].bin, vecs[i].value, vecs[i].exp_data, 1'b0, a0);
      wait_idle();
      chk("vec_sat", 32'(o_sat), 32'(vecs[i].exp_sat));
      chk("vec_mem", 32'(mem[vecs[i].bin]), 32'(vecs[i].exp_data));
    end

    // Back-to-back same-bin increments with i_valid held.
    do_clear(1'b0);
    send(7'd5, 8'd3, sadd(model[5], 8'd3), 1'b1, a0);
    send(7'd5, 8'd3, sadd(model[5], 8'd3), 1'b0, a1);
    chk("b2b_gap", 32'(a1 - a0), 32'd4);
    wait_idle();
    chk("b2b_mem5", 32'(mem[5]), 32'd6);
    chk("b2b_sat", 32'(o_sat), 32'd0);

    // Held valid across bins 0, 127, 0.
    send(7'd0,   8'd20, sadd(model[0],   8'd20), 1'b1, a0);
    send(7'd127, 8'd20, sadd(model[127], 8'd20), 1'b1, a1);
    send(7'd0,   8'd20, sadd(model[0],   8'd20), 1'b0, a2);
    chk("held_gap1", 32'(a1 - a0), 32'd4);
    chk("held_gap2", 32'(a2 - a1), 32'd4);
    wait_idle();
    chk("held_mem0", 32'(mem[0]), 32'd40);
    chk("held_mem127", 32'(mem[127]), 32'd20);
    chk("held_mem1", 32'(mem[1]), 32'd0);

    // Clear while a request is busy must be ignored.
    send(7'd3, 8'd1, sadd(model[3], 8'd1), 1'b0, a0);
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    wait_idle();
    @(negedge clk);
    chk("late_clear_ignored", 32'(o_busy), 32'd0);
    chk("late_clear_mem3", 32'(mem[3]), 32'd1);

    // Saturate, then clear with a simultaneous request.
    send(7'd9, 8'd250, sadd(model[9], 8'd250), 1'b0, a0);
    send(7'd9, 8'd10,  sadd(model[9], 8'd10),  1'b0, a0);
    wait_idle();
    chk("sat_set", 32'(o_sat), 32'd1);
    chk("sat_mem9", 32'(mem[9]), 32'd255);
    repeat (3) @(negedge clk);
    chk("sat_sticky", 32'(o_sat), 32'd1);
    do_clear(1'b1);

    // Reset in the ADD state discards the pending write.
    send(7'd2, 8'd7, sadd(model[2], 8'd7), 1'b0, a0);
    @(negedge clk);
    chk("in_add_busy", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrmw_rst_busy", 32'(o_busy), 32'd0);
    chk("midrmw_rst_write", 32'(o_mem_write), 32'd0);
    void'(exp_q.pop_back());
    model[2] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_ready", 32'(o_ready), 32'd1);
    chk("post_rst_mem2", 32'(mem[2]), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bin_accumulator.md
BIN_ACCUMULATOR -- requirements
Module: bin_accumulator

Interface
REQ-001 Parameter ADDR_WIDTH, default 7: bin address width.
REQ-002 Parameter DATA_WIDTH, default 8: stored sum width.
REQ-003 Parameter DEPTH, default 128: number of bins.
REQ-004 Parameter IN_WIDTH, default 8: width of the unsigned increment.
REQ-005 clk  input  1: the single clock; all logic on posedge.
REQ-006 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-007 i_valid  input  1: an increment request is present.
REQ-008 o_ready  output  1: the block accepts a request this cycle.
REQ-009 i_bin  input  ADDR_WIDTH: bin to increment.
REQ-010 i_value  input  IN_WIDTH: unsigned increment.
REQ-011 i_clear  input  1: start-of-frame clear request.
REQ-012 o_busy  output  1: an RMW or clear sweep is in progress.
REQ-013 o_clear_done  output  1: one-cycle pulse when a clear sweep ends.
REQ-014 o_sat  output  1: sticky flag; at least one add has saturated.
REQ-015 o_mem_addr  output  ADDR_WIDTH: sum-memory port address.
REQ-016 o_mem_write  output  1: sum-memory write enable.
REQ-017 o_mem_wdata  output  DATA_WIDTH: sum-memory write data.
REQ-018 i_mem_rdata  input  DATA_WIDTH: sum-memory read data, registered, valid 1 cycle after address with write low.

Function
REQ-019 FSM states: IDLE, READ, ADD, WRITE, CLEAR.
REQ-020 Ready rule: o_ready is 1 only in IDLE; a request is accepted on a posedge with i_valid=1, o_ready=1 and i_clear=0.
REQ-021 On accept, latch i_bin and i_value; transition IDLE->READ.
REQ-022 READ: o_mem_addr=bin, o_mem_write=0; transition to ADD.
REQ-023 ADD: register sum = i_mem_rdata + value, computed at DATA_WIDTH+1 bits; transition to WRITE.
REQ-024 Saturation: if the sum exceeds 2^DATA_WIDTH-1, o_mem_wdata is all-ones and o_sat is set.
REQ-025 WRITE: o_mem_addr=bin, o_mem_write=1 for exactly one cycle; transition to IDLE.
REQ-026 Timing: an accept at edge N writes at edge N+3; sustained throughput is one request per 4 cycles.
REQ-027 Same-bin ordering: back-to-back requests to the same bin are exact, because each write completes before the next read is issued.
REQ-028 Clear start: i_clear=1 in IDLE enters CLEAR with address 0; i_clear has priority over a simultaneous i_valid, which is not accepted.
REQ-029 CLEAR: each cycle write 0 to the current address (o_mem_write=1) and increment the address.
REQ-030 Clear end: after the write to DEPTH-1, return to IDLE, pulse o_clear_done for one cycle and clear o_sat; the sweep takes DEPTH cycles.
REQ-031 i_clear outside IDLE is ignored.
REQ-032 o_busy=1 in every state other than IDLE.
REQ-033 o_mem_write is 0 in IDLE, READ and ADD.

Reset
REQ-034 rst_n low forces IDLE immediately, including mid-RMW or mid-sweep; the pending write is discarded.
REQ-035 Reset values: o_ready=1 once rst_n is high; o_busy, o_clear_done, o_sat, o_mem_write = 0; o_mem_addr, o_mem_wdata = 0.

Structure
REQ-036 Package accum_pkg holds the state enumeration and the default width/depth constants.
REQ-037 One sub-module, sat_adder (combinational saturating add, DATA_WIDTH + IN_WIDTH operands), is instantiated once.

Verification
REQ-038 Reset, clear, then bin 5 += 3 twice -> mem[5]=6; writes at edges N+3 and N+7; o_sat=0.
REQ-039 mem[9]=250, bin 9 += 10 -> mem[9]=255, o_sat=1 and stays 1 until the next clear.
REQ-040 i_clear and i_valid asserted together in IDLE -> clear runs, request not accepted, o_clear_done after exactly 128 cycles, all bins read 0.
REQ-041 rst_n low during ADD of bin 2 += 7 -> no write to bin 2; o_ready=1 after release.
REQ-042 i_valid held high with bins 0,127,0 -> o_ready low 3 of every 4 cycles; mem[0]=2*value; mem[127]=value (address wrap untouched).
